// File: rtl/piece_ctrl.sv
// Registered active-piece and stacked-board controller: gravity with lock delay,
// sequential hard drop, 3-candidate wall-kick rotation, hold slot, game-over detection.
module piece_ctrl #(
   parameter int unsigned BOARD_W    = 10,
   parameter int unsigned BOARD_H    = 20,
   parameter int unsigned LOCK_DELAY = 2,
   parameter int unsigned SPAWN_X    = BOARD_W / 2 - 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         fall_en,
   input  logic                         down_en,
   input  logic                         left_en,
   input  logic                         right_en,
   input  logic                         rotate_en,
   input  logic                         drop_en,
   input  logic                         hold_en,
   input  logic [2:0]                   random_blk,
   input  logic                         board_load,
   input  logic [BOARD_W*BOARD_H-1:0]   board_in,
   output logic [BOARD_W*BOARD_H-1:0]   stacked_block,
   output logic [2:0]                   ctrl_blk,
   output logic [$clog2(BOARD_W)-1:0]   ctrl_pos_x,
   output logic [$clog2(BOARD_H)-1:0]   ctrl_pos_y,
   output logic [1:0]                   ctrl_rot,
   output logic [2:0]                   hold_blk,
   output logic                         hold_valid,
   output logic                         rnd_take,
   output logic                         lock_pulse,
   output logic                         fall_reset,
   output logic                         busy,
   output logic                         game_over
);

   localparam int unsigned CELLS = BOARD_W * BOARD_H;
   localparam int unsigned XW    = $clog2(BOARD_W);
   localparam int unsigned YW    = $clog2(BOARD_H);
   localparam int unsigned XPW   = XW + 1;
   localparam int unsigned YPW   = YW + 1;
   localparam int unsigned CXW   = XW + 2;
   localparam int unsigned CYW   = YW + 2;
   localparam int unsigned IW    = $clog2(CELLS);
   localparam int unsigned LW    = (LOCK_DELAY < 1) ? 1 : $clog2(LOCK_DELAY + 1);

   localparam logic [CXW-1:0] X_LIM = CXW'(BOARD_W);
   localparam logic [CYW-1:0] Y_LIM = CYW'(BOARD_H);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_DROP  = 3'd1;
   localparam logic [2:0] S_KICK1 = 3'd2;
   localparam logic [2:0] S_KICK2 = 3'd3;
   localparam logic [2:0] S_LOCK  = 3'd4;
   localparam logic [2:0] S_SPAWN = 3'd5;
   localparam logic [2:0] S_OVER  = 3'd6;

   // 4x4 occupancy per type/rotation, bit = row*4+col, anchored at the piece's top-left
   function automatic logic [15:0] shape(input logic [2:0] t, input logic [1:0] r);
      logic [15:0] s;
      s = 16'h0033;
      case (t)
         3'd0: s = r[0] ? 16'h1111 : 16'h000F;
         3'd1: s = 16'h0033;
         3'd2: begin
            case (r)
               2'd0:    s = 16'h0027;
               2'd1:    s = 16'h0232;
               2'd2:    s = 16'h0072;
               default: s = 16'h0131;
            endcase
         end
         3'd3: s = r[0] ? 16'h0231 : 16'h0036;
         3'd4: s = r[0] ? 16'h0132 : 16'h0063;
         3'd5: begin
            case (r)
               2'd0:    s = 16'h0071;
               2'd1:    s = 16'h0113;
               2'd2:    s = 16'h0047;
               default: s = 16'h0322;
            endcase
         end
         3'd6: begin
            case (r)
               2'd0:    s = 16'h0074;
               2'd1:    s = 16'h0311;
               2'd2:    s = 16'h0017;
               default: s = 16'h0223;
            endcase
         end
         default: s = 16'h0033;
      endcase
      return s;
   endfunction

   function automatic logic [IW-1:0] cell_idx(input logic [CXW-1:0] cx, input logic [CYW-1:0] cy);
      return IW'(32'(cy) * BOARD_W + 32'(cx));
   endfunction

   // Candidate placement check; x/y are one bit wider so x-1 from 0 lands out of range
   function automatic logic fits(input logic [2:0] t, input logic [1:0] r,
                                 input logic [XPW-1:0] x, input logic [YPW-1:0] y,
                                 input logic [CELLS-1:0] b);
      logic [15:0]    s;
      logic [CXW-1:0] cx;
      logic [CYW-1:0] cy;
      logic           ok;
      s  = shape(t, r);
      ok = 1'b1;
      for (int i = 0; i < 16; i++) begin
         cx = CXW'(x) + CXW'(i % 4);
         cy = CYW'(y) + CYW'(i / 4);
         if (s[i]) begin
            if (cx >= X_LIM || cy >= Y_LIM) ok = 1'b0;
            else if (b[cell_idx(cx, cy)]) ok = 1'b0;
         end
      end
      return ok;
   endfunction

   function automatic logic [CELLS-1:0] piece_mask(input logic [2:0] t, input logic [1:0] r,
                                                   input logic [XPW-1:0] x, input logic [YPW-1:0] y);
      logic [15:0]      s;
      logic [CXW-1:0]   cx;
      logic [CYW-1:0]   cy;
      logic [CELLS-1:0] m;
      s = shape(t, r);
      m = '0;
      for (int i = 0; i < 16; i++) begin
         cx = CXW'(x) + CXW'(i % 4);
         cy = CYW'(y) + CYW'(i / 4);
         if (s[i] && cx < X_LIM && cy < Y_LIM) m[cell_idx(cx, cy)] = 1'b1;
      end
      return m;
   endfunction

   logic [2:0]       state, state_nxt;
   logic [CELLS-1:0] board_nxt;
   logic [2:0]       blk_nxt;
   logic [XW-1:0]    x_nxt;
   logic [YW-1:0]    y_nxt;
   logic [1:0]       rot_nxt;
   logic [2:0]       hold_blk_nxt;
   logic             hold_valid_nxt;
   logic             hold_used, hold_used_nxt;
   logic [LW-1:0]    lock_cnt, lock_cnt_nxt;
   logic             pend_hold, pend_hold_nxt;
   logic [2:0]       pend_blk, pend_blk_nxt;
   logic             rnd_take_nxt, lock_pulse_nxt, fall_reset_nxt, game_over_nxt;

   logic [XPW-1:0]   x_cur, x_dec, x_inc;
   logic [YPW-1:0]   y_cur, y_inc;
   logic [1:0]       rot_inc;
   logic [2:0]       rnd_norm, spawn_type;
   logic             fit_down, fit_left, fit_right, fit_rot, fit_kick_l, fit_kick_r, fit_spawn;

   // Candidate positions and their fit results against the current board
   always_comb begin
      x_cur      = XPW'(ctrl_pos_x);
      y_cur      = YPW'(ctrl_pos_y);
      x_dec      = x_cur - XPW'(1);
      x_inc      = x_cur + XPW'(1);
      y_inc      = y_cur + YPW'(1);
      rot_inc    = ctrl_rot + 2'd1;
      rnd_norm   = (random_blk == 3'd7) ? 3'd0 : random_blk;
      spawn_type = pend_hold ? pend_blk : rnd_norm;
      fit_down   = fits(ctrl_blk, ctrl_rot, x_cur, y_inc, stacked_block);
      fit_left   = fits(ctrl_blk, ctrl_rot, x_dec, y_cur, stacked_block);
      fit_right  = fits(ctrl_blk, ctrl_rot, x_inc, y_cur, stacked_block);
      fit_rot    = fits(ctrl_blk, rot_inc, x_cur, y_cur, stacked_block);
      fit_kick_l = fits(ctrl_blk, rot_inc, x_dec, y_cur, stacked_block);
      fit_kick_r = fits(ctrl_blk, rot_inc, x_inc, y_cur, stacked_block);
      fit_spawn  = fits(spawn_type, 2'd0, XPW'(SPAWN_X), YPW'(0), stacked_block);
   end

   // Next-state and next-output logic
   always_comb begin
      state_nxt      = state;
      board_nxt      = stacked_block;
      blk_nxt        = ctrl_blk;
      x_nxt          = ctrl_pos_x;
      y_nxt          = ctrl_pos_y;
      rot_nxt        = ctrl_rot;
      hold_blk_nxt   = hold_blk;
      hold_valid_nxt = hold_valid;
      hold_used_nxt  = hold_used;
      lock_cnt_nxt   = lock_cnt;
      pend_hold_nxt  = pend_hold;
      pend_blk_nxt   = pend_blk;
      rnd_take_nxt   = 1'b0;
      lock_pulse_nxt = 1'b0;
      fall_reset_nxt = 1'b0;
      game_over_nxt  = game_over;

      case (state)
         S_IDLE: begin
            if (board_load) begin
               board_nxt = board_in;
            end else if (fall_en || down_en) begin
               if (fit_down) begin
                  y_nxt        = y_inc[YW-1:0];
                  lock_cnt_nxt = '0;
               end else if (lock_cnt == LW'(LOCK_DELAY)) begin
                  state_nxt = S_LOCK;
               end else begin
                  lock_cnt_nxt = lock_cnt + LW'(1);
               end
            end else if (left_en) begin
               if (fit_left) x_nxt = x_dec[XW-1:0];
            end else if (right_en) begin
               if (fit_right) x_nxt = x_inc[XW-1:0];
            end else if (rotate_en) begin
               if (fit_rot) rot_nxt = rot_inc;
               else         state_nxt = S_KICK1;
            end else if (drop_en) begin
               state_nxt = S_DROP;
            end else if (hold_en && !hold_used) begin
               hold_used_nxt  = 1'b1;
               hold_blk_nxt   = ctrl_blk;
               hold_valid_nxt = 1'b1;
               pend_hold_nxt  = hold_valid;
               pend_blk_nxt   = hold_blk;
               state_nxt      = S_SPAWN;
            end
         end
         S_DROP: begin
            if (fit_down) y_nxt = y_inc[YW-1:0];
            else          state_nxt = S_LOCK;
         end
         S_KICK1: begin
            if (fit_kick_l) begin
               x_nxt     = x_dec[XW-1:0];
               rot_nxt   = rot_inc;
               state_nxt = S_IDLE;
            end else begin
               state_nxt = S_KICK2;
            end
         end
         S_KICK2: begin
            if (fit_kick_r) begin
               x_nxt   = x_inc[XW-1:0];
               rot_nxt = rot_inc;
            end
            state_nxt = S_IDLE;
         end
         S_LOCK: begin
            board_nxt      = stacked_block | piece_mask(ctrl_blk, ctrl_rot, x_cur, y_cur);
            lock_pulse_nxt = 1'b1;
            hold_used_nxt  = 1'b0;
            lock_cnt_nxt   = '0;
            pend_hold_nxt  = 1'b0;
            state_nxt      = S_SPAWN;
         end
         S_SPAWN: begin
            blk_nxt        = spawn_type;
            x_nxt          = XW'(SPAWN_X);
            y_nxt          = '0;
            rot_nxt        = 2'd0;
            lock_cnt_nxt   = '0;
            fall_reset_nxt = 1'b1;
            rnd_take_nxt   = !pend_hold;
            pend_hold_nxt  = 1'b0;
            if (fit_spawn) begin
               state_nxt = S_IDLE;
            end else begin
               state_nxt     = S_OVER;
               game_over_nxt = 1'b1;
            end
         end
         S_OVER:  state_nxt = S_OVER;
         default: state_nxt = S_IDLE;
      endcase
   end

   // State and output registers; reset leaves the FSM in SPAWN
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_SPAWN;
         stacked_block <= '0;
         ctrl_blk      <= 3'd0;
         ctrl_pos_x    <= XW'(SPAWN_X);
         ctrl_pos_y    <= '0;
         ctrl_rot      <= 2'd0;
         hold_blk      <= 3'd0;
         hold_valid    <= 1'b0;
         hold_used     <= 1'b0;
         lock_cnt      <= '0;
         pend_hold     <= 1'b0;
         pend_blk      <= 3'd0;
         rnd_take      <= 1'b0;
         lock_pulse    <= 1'b0;
         fall_reset    <= 1'b0;
         game_over     <= 1'b0;
         busy          <= 1'b1;
      end else begin
         state         <= state_nxt;
         stacked_block <= board_nxt;
         ctrl_blk      <= blk_nxt;
         ctrl_pos_x    <= x_nxt;
         ctrl_pos_y    <= y_nxt;
         ctrl_rot      <= rot_nxt;
         hold_blk      <= hold_blk_nxt;
         hold_valid    <= hold_valid_nxt;
         hold_used     <= hold_used_nxt;
         lock_cnt      <= lock_cnt_nxt;
         pend_hold     <= pend_hold_nxt;
         pend_blk      <= pend_blk_nxt;
         rnd_take      <= rnd_take_nxt;
         lock_pulse    <= lock_pulse_nxt;
         fall_reset    <= fall_reset_nxt;
         game_over     <= game_over_nxt;
         busy          <= (state_nxt != S_IDLE);
      end
   end

endmodule

// File: doc/piece_ctrl.md
Name: piece_ctrl

Overview:
- Registered successor to the combinational next-piece logic.
- Owns the active piece state (type, x, y, rotation) and the stacked-board bitmap.
- Applies player and fall requests through a small FSM, adding a parametrised board size, lock delay, a sequential hard drop, a 3-candidate wall-kick rotation, a hold slot and game-over detection.
- Sits between the input/timer logic and the line-clear and render blocks.

Parameters:
- BOARD_W, 10, board width in cells.
- BOARD_H, 20, board height in cells.
- LOCK_DELAY, 2, grounded fall/down ticks absorbed before locking. 0 locks on the first grounded tick.
- SPAWN_X, BOARD_W/2-1, spawn column.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- fall_en  in  1  gravity tick
- down_en  in  1  soft-drop request
- left_en  in  1  move-left request
- right_en  in  1  move-right request
- rotate_en  in  1  rotate-clockwise request
- drop_en  in  1  hard-drop request
- hold_en  in  1  hold/swap request
- random_blk  in  3  next piece type from the RNG; values 0-6 valid, 7 treated as 0
- board_load  in  1  overwrite the board with board_in (line-clear result)
- board_in  in  BOARD_W*BOARD_H  replacement board
- stacked_block  out  BOARD_W*BOARD_H  stacked board; bit index = y*BOARD_W+x
- ctrl_blk  out  3  active piece type
- ctrl_pos_x  out  clog2(BOARD_W)  active piece x
- ctrl_pos_y  out  clog2(BOARD_H)  active piece y
- ctrl_rot  out  2  active rotation
- hold_blk  out  3  held piece type
- hold_valid  out  1  hold slot occupied
- rnd_take  out  1  one-cycle pulse: random_blk consumed
- lock_pulse  out  1  one-cycle pulse: piece merged into the board
- fall_reset  out  1  one-cycle pulse: restart the gravity timer
- busy  out  1  high in any state other than IDLE; requests are ignored
- game_over  out  1  sticky until rst

Behaviour:
- Reset values:
  - Board all 0; ctrl_blk 0, x SPAWN_X, y 0, rot 0.
  - hold_blk 0, hold_valid 0, hold_used 0, lock_cnt 0.
  - All pulse outputs 0; game_over 0.
  - Next state SPAWN, so the first piece spawns one cycle after rst deasserts.
  - rst mid-operation aborts any drop or kick; no partial board write.
- Cell geometry:
  - Internal 4x4 shape table per type and rotation.
  - A candidate fits iff every cell has x<BOARD_W and y<BOARD_H, and the board bit at each cell is 0.
  - Arithmetic uses widths one bit wider than the position fields so that x-1 from 0 flags an invalid candidate rather than wrapping.
- States: IDLE, DROP, KICK1, KICK2, LOCK, SPAWN, OVER.
- IDLE:
  - board_load has top priority; board <= board_in and all requests that cycle are ignored.
  - Otherwise requests are served in this order: fall_en|down_en, left_en, right_en, rotate_en, drop_en, hold_en. One request is served per cycle; the rest are dropped.
- Fall/down:
  - If the piece fits at y+1: y++, lock_cnt <= 0.
  - Else if lock_cnt == LOCK_DELAY: go to LOCK.
  - Else lock_cnt++.
- Left/right:
  - x-/+1 if the candidate fits; otherwise no change.
  - lock_cnt is unchanged.
- Rotate:
  - Test rot+1 (mod 4, 3 wraps to 0) at x in IDLE. If it fits, commit.
  - Else go to KICK1 and test x-1; if that fails, go to KICK2 and test x+1.
  - First fit commits both x and rot. If all three fail, nothing changes.
  - Return to IDLE either way; worst-case latency is 3 cycles.
- Drop (DROP state):
  - Each cycle: y++ if the piece fits at y+1; else go to LOCK.
  - Latency = rows fallen + 1 cycle.
- LOCK:
  - OR the 4 cells into the board; lock_pulse=1.
  - hold_used <= 0, lock_cnt <= 0; go to SPAWN.
- Hold (IDLE, only when hold_used=0; otherwise ignored):
  - hold_used <= 1; hold_blk <= ctrl_blk.
  - The piece swapped in is the old hold_blk if hold_valid, else random_blk.
  - hold_valid <= 1; go to SPAWN.
- SPAWN:
  - Load the new type, x=SPAWN_X, y=0, rot=0; fall_reset=1.
  - rnd_take=1 only when random_blk was used.
  - If the new piece does not fit, go to OVER; else go to IDLE.
- OVER:
  - game_over=1, busy=1; all inputs ignored, including board_load.
  - Board and piece are frozen until rst.
- Simultaneous events: requests asserted while busy are not queued.

Test Plan:
- rst, random_blk=3 -> 1 cycle later ctrl_blk=3, x=4, y=0, rot=0, rnd_take=1, fall_reset=1. Next cycle busy=0.
- O piece on an empty board, drop_en -> y steps to 18 over 18 cycles, then LOCK. Cells 184,185,194,195 are set, lock_pulse=1 for 1 cycle.
- Piece grounded, LOCK_DELAY=2, three fall_en ticks -> no lock on ticks 1-2; lock_pulse follows tick 3.
- I piece vertical at x=9, rotate_en -> x=9 and x=8 fail, x=10 is out of range. Piece unchanged, busy high for exactly 2 extra cycles.
- hold_en twice within one piece life -> first swaps in random_blk with hold_valid=1. Second is ignored until after the next lock_pulse.
- Board rows 0-1 filled via board_load, then lock -> SPAWN overlap gives game_over=1. fall_en/left_en then change nothing; rst clears game_over.
